// File: rtl/cabac_pkg.sv
// rtl/cabac_pkg.sv - shared CABAC constants and feeder state encoding
package cabac_pkg;
    localparam int VALUE_W    = 16;
    localparam int BYTE_W     = 8;
    localparam int INIT_BYTES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } feeder_state_t;
endpackage

// File: rtl/cabac_byte_buffer.sv
// rtl/cabac_byte_buffer.sv - bit buffer with bit counter; CABAC_FEEDER_PREFETCH_EN adds a spare byte
module cabac_byte_buffer #(
    parameter int BYTE_W = cabac_pkg::BYTE_W,
    parameter int CNT_W  = $clog2(BYTE_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              shift_i,
    output logic              bit_o,
    output logic [CNT_W-1:0]  bits_left_o,
    output logic              accept_o
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BYTE_W);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [BYTE_W-1:0] bitbuf_q, bitbuf_d;
    logic [CNT_W-1:0]  bits_q, bits_d;

    assign bit_o       = bitbuf_q[BYTE_W-1];
    assign bits_left_o = bits_q;

`ifdef CABAC_FEEDER_PREFETCH_EN
    logic [BYTE_W-1:0] spare_q, spare_d;
    logic              spare_full_q, spare_full_d;

    assign accept_o = ~spare_full_q;

    always_comb begin
        bitbuf_d     = bitbuf_q;
        bits_d       = bits_q;
        spare_d      = spare_q;
        spare_full_d = spare_full_q;
        if (flush_i) begin
            bitbuf_d     = '0;
            bits_d       = '0;
            spare_full_d = 1'b0;
        end else if (shift_i) begin
            // last bit leaves: refill from spare (or the arriving byte) to avoid a bubble
            if (bits_q == ONE && spare_full_q) begin
                bitbuf_d     = spare_q;
                bits_d       = FULL;
                spare_full_d = 1'b0;
            end else if (bits_q == ONE && load_i) begin
                bitbuf_d = byte_i;
                bits_d   = FULL;
            end else begin
                bitbuf_d = bitbuf_q << 1;
                bits_d   = bits_q - ONE;
                if (load_i) begin
                    spare_d      = byte_i;
                    spare_full_d = 1'b1;
                end
            end
        end else if (load_i) begin
            if (bits_q == '0) begin
                bitbuf_d = byte_i;
                bits_d   = FULL;
            end else begin
                spare_d      = byte_i;
                spare_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spare_q      <= '0;
            spare_full_q <= 1'b0;
        end else begin
            spare_q      <= spare_d;
            spare_full_q <= spare_full_d;
        end
    end
`else
    // load only happens when empty and shift only when non-empty, so they never coincide
    assign accept_o = (bits_q == '0);

    always_comb begin
        bitbuf_d = bitbuf_q;
        bits_d   = bits_q;
        if (flush_i) begin
            bitbuf_d = '0;
            bits_d   = '0;
        end else if (load_i) begin
            bitbuf_d = byte_i;
            bits_d   = FULL;
        end else if (shift_i) begin
            bitbuf_d = bitbuf_q << 1;
            bits_d   = bits_q - ONE;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitbuf_q <= '0;
            bits_q   <= '0;
        end else begin
            bitbuf_q <= bitbuf_d;
            bits_q   <= bits_d;
        end
    end
endmodule

// File: rtl/cabac_bit_feeder.sv
// rtl/cabac_bit_feeder.sv - m_value register and bitstream refill for DecodeBinEP
// Optional CABAC_FEEDER_PREFETCH_EN (in cabac_byte_buffer) removes the refill bubble.
module cabac_bit_feeder #(
    parameter int VALUE_W = cabac_pkg::VALUE_W,
    parameter int BYTE_W  = cabac_pkg::BYTE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BYTE_W-1:0]  byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               init_done,
    output logic [VALUE_W-1:0] m_value_out,
    output logic [VALUE_W:0]   new_m_value,
    output logic               value_valid,
    input  logic               bin_done,
    input  logic [VALUE_W-1:0] m_value_upd
);
    import cabac_pkg::*;

    localparam int CNT_W      = $clog2(BYTE_W + 1);
    localparam int INIT_CNT_W = (INIT_BYTES > 1) ? $clog2(INIT_BYTES) : 1;
    localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(INIT_BYTES - 1);

    feeder_state_t          state_q, state_d;
    logic [INIT_CNT_W-1:0]  init_cnt_q, init_cnt_d;
    logic [VALUE_W-1:0]     m_value_q, m_value_d;

    logic                   buf_bit;
    logic [CNT_W-1:0]       bits_left;
    logic                   buf_accept;
    logic                   xfer;
    logic                   bin_take;

    // start blocks the handshake so a byte is never accepted into a buffer being flushed
    assign byte_ready  = ~start & ((state_q == INIT) | ((state_q == RUN) & buf_accept));
    assign xfer        = byte_valid & byte_ready;
    assign value_valid = (state_q == RUN) & (bits_left != '0);
    assign bin_take    = bin_done & value_valid;
    assign init_done   = (state_q == RUN);
    assign m_value_out = m_value_q;
    assign new_m_value = {m_value_q, buf_bit};

    cabac_byte_buffer #(
        .BYTE_W (BYTE_W),
        .CNT_W  (CNT_W)
    ) u_byte_buffer (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (start),
        .load_i      (xfer & (state_q == RUN)),
        .byte_i      (byte_in),
        .shift_i     (bin_take),
        .bit_o       (buf_bit),
        .bits_left_o (bits_left),
        .accept_o    (buf_accept)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        m_value_d  = m_value_q;
        if (start) begin
            state_d    = INIT;
            init_cnt_d = '0;
        end else begin
            case (state_q)
                INIT: begin
                    if (xfer) begin
                        m_value_d = {m_value_q[VALUE_W-BYTE_W-1:0], byte_in};
                        if (init_cnt_q == INIT_LAST) begin
                            state_d = RUN;
                        end else begin
                            init_cnt_d = init_cnt_q + INIT_CNT_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (bin_take) begin
                        m_value_d = m_value_upd;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            init_cnt_q <= '0;
            m_value_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            m_value_q  <= m_value_d;
        end
    end
endmodule

// File: tb/tb_cabac_bit_feeder.sv
// tb/tb_cabac_bit_feeder.sv - scoreboard bench for cabac_bit_feeder (CABAC_FEEDER_PREFETCH_EN aware)
module tb_cabac_bit_feeder;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        init_done;
    logic [15:0] m_value_out;
    logic [16:0] new_m_value;
    logic        value_valid;
    logic        bin_done;
    logic [15:0] m_value_upd;

    int total = 0;
    int bad   = 0;

    logic [32:0] sb[$];
    logic [15:0] mv;
    logic [7:0]  bbuf;

    always #5 clk = ~clk;

    cabac_bit_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .init_done   (init_done),
        .m_value_out (m_value_out),
        .new_m_value (new_m_value),
        .value_valid (value_valid),
        .bin_done    (bin_done),
        .m_value_upd (m_value_upd)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (byte_ready) done = 1'b1;
            step();
        end
        byte_valid = 1'b0;
        check("send_byte_accepted", done, 1'b1);
    endtask

    task automatic do_bin(input logic [15:0] upd);
        bit got = 1'b0;
        sb.push_back({mv, mv, bbuf[7]});
        bin_done    = 1'b1;
        m_value_upd = upd;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (value_valid) got = 1'b1;
            step();
        end
        bin_done = 1'b0;
        check("bin_accepted", got, 1'b1);
        mv   = upd;
        bbuf = bbuf << 1;
    endtask

    function automatic logic [15:0] upd_of(input int k);
        return 16'h3000 + 16'(k) * 16'h0101;
    endfunction

    // monitor: every consumed bin must present the queued expected value pair
    always @(negedge clk) begin
        if (!rst && value_valid && bin_done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL bin_value: got %0h with no expected entry queued", {m_value_out, new_m_value});
            end else begin
                check("bin_value", {m_value_out, new_m_value}, sb.pop_front());
            end
        end
    end

    initial begin
        int cnt;
        int lows;
        int vbad;
        int hbad;
        bit v;
        bit r;
        logic [15:0] tmv;
        logic [7:0]  tbuf;
        int exp_lows;

        rst = 1'b1; start = 1'b0; byte_in = 8'h77; byte_valid = 1'b1;
        bin_done = 1'b0; m_value_upd = '0;
        mv = '0; bbuf = '0;

        // reset with a byte offered
        @(negedge clk);
        check("rst_byte_ready", byte_ready, 1'b0);
        check("rst_value_valid", value_valid, 1'b0);
        check("rst_m_value", m_value_out, 16'h0000);
        check("rst_init_done", init_done, 1'b0);
        step();
        rst = 1'b0; byte_valid = 1'b0;
        step();

        // init: two bytes form m_value
        start = 1'b1;
        step();
        start = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h3C);
        @(negedge clk);
        check("init_m_value", m_value_out, 16'hA53C);
        check("init_done", init_done, 1'b1);
        check("init_value_valid", value_valid, 1'b0);
        check("init_byte_ready", byte_ready, 1'b1);
        mv = 16'hA53C;
        step();

        // bin shift
        send_byte(8'h80);
        bbuf = 8'h80;
        @(negedge clk);
        check("load_value_valid", value_valid, 1'b1);
        check("first_new_m_value", new_m_value, 17'h14A79);
        step();
        do_bin(16'h1234);
        @(negedge clk);
        check("shift_m_value", m_value_out, 16'h1234);
        check("shift_new_m_value", new_m_value, 17'h02468);
        step();
        for (int i = 0; i < 7; i++) do_bin(16'h2000 + 16'(i));
        @(negedge clk);
        check("empty_value_valid", value_valid, 1'b0);
        step();

        // byte boundary with a byte waiting
        send_byte(8'hC3);
        bbuf = 8'hC3;
        tmv = mv; tbuf = bbuf;
        for (int k = 0; k < 16; k++) begin
            if (k == 8) tbuf = 8'h5A;
            sb.push_back({tmv, tmv, tbuf[7]});
            tmv  = upd_of(k);
            tbuf = tbuf << 1;
        end
        mv = tmv; bbuf = 8'h00;
        byte_in = 8'h5A; byte_valid = 1'b1;
        bin_done = 1'b1; m_value_upd = upd_of(0);
        cnt = 0; lows = 0;
        for (int c = 0; c < 60 && cnt < 16; c++) begin
            @(negedge clk);
            v = value_valid;
            r = byte_ready & byte_valid;
            step();
            if (v) cnt++;
            else if (cnt > 0) lows++;
            if (r) byte_valid = 1'b0;
            m_value_upd = upd_of(cnt);
        end
        bin_done = 1'b0; byte_valid = 1'b0;
`ifdef CABAC_FEEDER_PREFETCH_EN
        exp_lows = 0;
`else
        exp_lows = 1;
`endif
        check("boundary_bins", cnt, 16);
        check("boundary_low_cycles", lows, exp_lows);

        // starvation: bin_done ignored, m_value held
        vbad = 0; hbad = 0;
        bin_done = 1'b1; m_value_upd = 16'hDEAD;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (value_valid !== 1'b0) vbad++;
            if (m_value_out !== mv) hbad++;
            step();
        end
        bin_done = 1'b0;
        check("starve_valid_cycles", vbad, 0);
        check("starve_hold_cycles", hbad, 0);
        @(negedge clk);
        check("starve_m_value", m_value_out, mv);
        check("starve_byte_ready", byte_ready, 1'b1);
        step();

        // restart mid-RUN with bits left
        send_byte(8'hF0);
        bbuf = 8'hF0;
        do_bin(16'h0AAA);
        do_bin(16'h0BBB);
        do_bin(16'h0CCC);
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        check("restart_init_done", init_done, 1'b0);
        check("restart_value_valid", value_valid, 1'b0);
        step();
        send_byte(8'h9B);
        send_byte(8'h61);
        @(negedge clk);
        check("restart_m_value", m_value_out, 16'h9B61);
        check("restart_flushed_valid", value_valid, 1'b0);
        step();
        mv = 16'h9B61;
        send_byte(8'h01);
        bbuf = 8'h01;
        do_bin(16'h7777);

        // reset mid-operation with a byte offered
        byte_in = 8'hFF; byte_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        check("midrst_byte_ready", byte_ready, 1'b0);
        check("midrst_value_valid", value_valid, 1'b0);
        check("midrst_m_value", m_value_out, 16'h0000);
        check("midrst_new_m_value", new_m_value, 17'h00000);
        step();
        rst = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        check("midrst_idle", init_done, 1'b0);

        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
